// File: rtl/hazard_control_unit_pkg.sv
// ============================================================================
// hazard_control_unit_pkg : shared encodings and widths for the hazard unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_MEM_WAIT = 2'b11
    } state_e;

    localparam int unsigned CNT_WIDTH = 16;
    localparam int unsigned WD_WIDTH  = 8;
    localparam logic [WD_WIDTH-1:0] WATCHDOG_LIMIT = 8'd255;

    // The zero register never carries a real dependency.
    function automatic logic load_use_hazard(
        input logic       valid,
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return valid && memread && (rd != 5'd0) &&
               (((rd == rs1) && uses_rs1) || ((rd == rs2) && uses_rs2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones, synchronous active-low clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != MAX)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit : load-use stall, redirect flush and memory-wait freeze
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit
    import hazard_control_unit_pkg::*;
(
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_ifid_valid,
    input  logic [4:0]           in_ifid_rs1,
    input  logic [4:0]           in_ifid_rs2,
    input  logic                 in_ifid_uses_rs1,
    input  logic                 in_ifid_uses_rs2,
    input  logic                 in_idex_memread,
    input  logic [4:0]           in_idex_rd,
    input  logic                 in_ex_redirect,
    input  logic                 in_dmem_busy,
    output logic                 out_pc_write,
    output logic                 out_ifid_write,
    output logic                 out_idex_bubble,
    output logic                 out_ifid_flush,
    output logic                 out_idex_flush,
    output logic                 out_exmem_write,
    output logic                 out_memwb_write,
    output logic [1:0]           out_state,
    output logic [CNT_WIDTH-1:0] out_stall_count,
    output logic [CNT_WIDTH-1:0] out_flush_count,
    output logic                 out_mem_timeout
);

    localparam logic [WD_WIDTH-1:0] WD_ONE = {{(WD_WIDTH-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [WD_WIDTH-1:0] wd_q, wd_d;
    logic                timeout_q, timeout_d;
    logic                w_hazard;
    logic                w_stall_inc;
    logic                w_flush_inc;

    assign w_hazard = load_use_hazard(in_ifid_valid, in_idex_memread, in_idex_rd,
                                      in_ifid_rs1, in_ifid_rs2,
                                      in_ifid_uses_rs1, in_ifid_uses_rs2);

    always_comb begin
        state_d         = state_q;
        out_pc_write    = 1'b1;
        out_ifid_write  = 1'b1;
        out_idex_bubble = 1'b0;
        out_ifid_flush  = 1'b0;
        out_idex_flush  = 1'b0;
        out_exmem_write = 1'b1;
        out_memwb_write = 1'b1;
        w_stall_inc     = 1'b0;
        w_flush_inc     = 1'b0;
        // Outputs stay at their defaults while reset is held.
        if (in_rst_n) begin
            case (state_q)
                ST_RUN, ST_LU_STALL, ST_FLUSH: begin
                    if (in_dmem_busy) begin
                        out_pc_write    = 1'b0;
                        out_ifid_write  = 1'b0;
                        out_exmem_write = 1'b0;
                        out_memwb_write = 1'b0;
                        state_d         = ST_MEM_WAIT;
                    end else if (in_ex_redirect) begin
                        out_ifid_flush = 1'b1;
                        out_idex_flush = 1'b1;
                        w_flush_inc    = 1'b1;
                        state_d        = ST_FLUSH;
                    end else if ((state_q == ST_RUN) && w_hazard) begin
                        out_pc_write    = 1'b0;
                        out_ifid_write  = 1'b0;
                        out_idex_bubble = 1'b1;
                        w_stall_inc     = 1'b1;
                        state_d         = ST_LU_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    w_stall_inc = 1'b1;
                    if (in_dmem_busy) begin
                        out_pc_write    = 1'b0;
                        out_ifid_write  = 1'b0;
                        out_exmem_write = 1'b0;
                        out_memwb_write = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        wd_d = '0;
        if (state_q == ST_MEM_WAIT) begin
            wd_d = (wd_q == WATCHDOG_LIMIT) ? wd_q : (wd_q + WD_ONE);
        end
        timeout_d = timeout_q | (wd_d == WATCHDOG_LIMIT);
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q   <= ST_RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i   (in_clk),
        .rst_ni  (in_rst_n),
        .inc_i   (w_stall_inc),
        .count_o (out_stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i   (in_clk),
        .rst_ni  (in_rst_n),
        .inc_i   (w_flush_inc),
        .count_o (out_flush_count)
    );

    assign out_state       = state_q;
    assign out_mem_timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// tb_hazard_control_unit : directed stimulus with queued expectations
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [4:0] rs1 = 5'd0;
    logic [4:0] rs2 = 5'd0;
    logic       u1 = 1'b0;
    logic       u2 = 1'b0;
    logic       mr = 1'b0;
    logic [4:0] rd = 5'd0;
    logic       redir = 1'b0;
    logic       busy = 1'b0;

    logic        pc_w, ifid_w, bub, ifid_fl, idex_fl, exm_w, mwb_w, tmo;
    logic [1:0]  st;
    logic [15:0] sc, fc;

    always #5 clk = ~clk;

    hazard_control_unit dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_ifid_valid    (valid),
        .in_ifid_rs1      (rs1),
        .in_ifid_rs2      (rs2),
        .in_ifid_uses_rs1 (u1),
        .in_ifid_uses_rs2 (u2),
        .in_idex_memread  (mr),
        .in_idex_rd       (rd),
        .in_ex_redirect   (redir),
        .in_dmem_busy     (busy),
        .out_pc_write     (pc_w),
        .out_ifid_write   (ifid_w),
        .out_idex_bubble  (bub),
        .out_ifid_flush   (ifid_fl),
        .out_idex_flush   (idex_fl),
        .out_exmem_write  (exm_w),
        .out_memwb_write  (mwb_w),
        .out_state        (st),
        .out_stall_count  (sc),
        .out_flush_count  (fc),
        .out_mem_timeout  (tmo)
    );

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       redir;
        logic       busy;
    } stim_t;

    // ctl order: pc_write, ifid_write, bubble, ifid_flush, idex_flush, exmem_write, memwb_write
    typedef struct packed {
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        to;
    } obs_t;

    typedef struct {
        int unsigned cyc;
        obs_t        exp;
        string       nm;
    } sb_t;

    localparam logic [6:0] DEF = 7'b1100011;
    localparam logic [6:0] BUB = 7'b0010011;
    localparam logic [6:0] FLS = 7'b1101111;
    localparam logic [6:0] FRZ = 7'b0000000;

    sb_t         sbq[$];
    sb_t         cur;
    int unsigned cyc_n = 0;
    int          total = 0;
    int          bad = 0;
    obs_t        act;

    assign act = {pc_w, ifid_w, bub, ifid_fl, idex_fl, exm_w, mwb_w, st, sc, fc, tmo};

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        while ((sbq.size() > 0) && (sbq[0].cyc < cyc_n)) begin
            cur = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL %s: no sample taken for cycle %0d (now %0d)", cur.nm, cur.cyc, cyc_n);
        end
        if ((sbq.size() > 0) && (sbq[0].cyc == cyc_n)) begin
            cur = sbq.pop_front();
            total++;
            if (act !== cur.exp) begin
                bad++;
                $display("FAIL %s: got ctl=%b st=%0d stall=%0d flush=%0d to=%b, expected ctl=%b st=%0d stall=%0d flush=%0d to=%b",
                         cur.nm, act.ctl, act.st, act.sc, act.fc, act.to,
                         cur.exp.ctl, cur.exp.st, cur.exp.sc, cur.exp.fc, cur.exp.to);
            end
        end
    end

    function automatic stim_t mk(input logic r, input logic v, input logic [4:0] a, input logic [4:0] b,
                                 input logic x1, input logic x2, input logic m, input logic [4:0] d,
                                 input logic rr, input logic bz);
        stim_t s;
        s = {r, v, a, b, x1, x2, m, d, rr, bz};
        return s;
    endfunction

    task automatic step(input stim_t s, input bit chk, input logic [6:0] ctl, input logic [1:0] est,
                        input logic [15:0] esc, input logic [15:0] efc, input logic eto, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n = s.rst_n;
        valid = s.valid;
        rs1   = s.rs1;
        rs2   = s.rs2;
        u1    = s.u1;
        u2    = s.u2;
        mr    = s.mr;
        rd    = s.rd;
        redir = s.redir;
        busy  = s.busy;
        if (chk) begin
            e.cyc = cyc_n;
            e.exp = {ctl, est, esc, efc, eto};
            e.nm  = nm;
            sbq.push_back(e);
        end
    endtask

    stim_t S_N, S_H, S_Z, S_U2, S_IV, S_HR, S_R, S_B, S_HB, S_BR, S_RST;

    initial begin
        S_N   = mk(1, 1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0);
        S_H   = mk(1, 1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 0, 0);
        S_Z   = mk(1, 1, 5'd0, 5'd2, 1, 1, 1, 5'd0, 0, 0);
        S_U2  = mk(1, 1, 5'd3, 5'd7, 1, 0, 1, 5'd7, 0, 0);
        S_IV  = mk(1, 0, 5'd1, 5'd5, 1, 1, 1, 5'd5, 0, 0);
        S_HR  = mk(1, 1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 1, 0);
        S_R   = mk(1, 1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0);
        S_B   = mk(1, 1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1);
        S_HB  = mk(1, 1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 0, 1);
        S_BR  = mk(1, 1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 1);
        S_RST = mk(0, 1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 1, 1);

        step(S_RST, 1, DEF, 2'd0, 16'd0, 16'd0, 1'b0, "reset_masked");
        step(S_N,   1, DEF, 2'd0, 16'd0, 16'd0, 1'b0, "run_idle");
        step(S_H,   1, BUB, 2'd0, 16'd0, 16'd0, 1'b0, "lu_bubble");
        step(S_H,   1, DEF, 2'd1, 16'd1, 16'd0, 1'b0, "lu_stall_masked");
        step(S_N,   1, DEF, 2'd0, 16'd1, 16'd0, 1'b0, "lu_back_run");
        step(S_Z,   1, DEF, 2'd0, 16'd1, 16'd0, 1'b0, "zero_reg");
        step(S_N,   1, DEF, 2'd0, 16'd1, 16'd0, 1'b0, "zero_reg_run");
        step(S_U2,  1, DEF, 2'd0, 16'd1, 16'd0, 1'b0, "rs2_unused");
        step(S_IV,  1, DEF, 2'd0, 16'd1, 16'd0, 1'b0, "ifid_invalid");
        step(S_HR,  1, FLS, 2'd0, 16'd1, 16'd0, 1'b0, "conflict_flush");
        step(S_N,   1, DEF, 2'd2, 16'd1, 16'd1, 1'b0, "flush_state");
        step(S_N,   1, DEF, 2'd0, 16'd1, 16'd1, 1'b0, "flush_back_run");
        step(S_R,   1, FLS, 2'd0, 16'd1, 16'd1, 1'b0, "redir_run");
        step(S_R,   1, FLS, 2'd2, 16'd1, 16'd2, 1'b0, "redir_in_flush");
        step(S_N,   1, DEF, 2'd2, 16'd1, 16'd3, 1'b0, "flush_again");
        step(S_N,   1, DEF, 2'd0, 16'd1, 16'd3, 1'b0, "flush_done");
        step(S_HB,  1, FRZ, 2'd0, 16'd1, 16'd3, 1'b0, "busy_over_hazard");
        step(S_BR,  1, FRZ, 2'd3, 16'd1, 16'd3, 1'b0, "memwait_redir_ignored");
        step(S_B,   1, FRZ, 2'd3, 16'd2, 16'd3, 1'b0, "memwait_hold");
        step(S_N,   1, DEF, 2'd3, 16'd3, 16'd3, 1'b0, "memwait_exit");
        step(S_N,   1, DEF, 2'd0, 16'd4, 16'd3, 1'b0, "memwait_stall3");
        step(S_H,   1, BUB, 2'd0, 16'd4, 16'd3, 1'b0, "lu_bubble2");
        step(S_B,   1, FRZ, 2'd1, 16'd5, 16'd3, 1'b0, "busy_in_lu");
        step(S_N,   1, DEF, 2'd3, 16'd5, 16'd3, 1'b0, "memwait_exit2");
        step(S_N,   1, DEF, 2'd0, 16'd6, 16'd3, 1'b0, "run_again");
        step(S_H,   1, BUB, 2'd0, 16'd6, 16'd3, 1'b0, "lu_bubble3");
        step(S_HR,  1, FLS, 2'd1, 16'd7, 16'd3, 1'b0, "redir_in_lu");
        step(S_N,   1, DEF, 2'd2, 16'd7, 16'd4, 1'b0, "flush_after_lu");
        step(S_N,   1, DEF, 2'd0, 16'd7, 16'd4, 1'b0, "run_after_lu");

        // Watchdog: 260 busy cycles starting from RUN.
        for (int k = 0; k < 260; k++) begin
            if (k == 255)
                step(S_B, 1, FRZ, 2'd3, 16'd261, 16'd4, 1'b0, "wd_before_limit");
            else if (k == 256)
                step(S_B, 1, FRZ, 2'd3, 16'd262, 16'd4, 1'b1, "wd_at_limit");
            else
                step(S_B, 0, FRZ, 2'd0, 16'd0, 16'd0, 1'b0, "");
        end
        step(S_N, 1, DEF, 2'd3, 16'd266, 16'd4, 1'b1, "wd_exit");
        step(S_N, 1, DEF, 2'd0, 16'd267, 16'd4, 1'b1, "wd_sticky");

        // Saturation: a long memory wait pushes the stall counter past its maximum.
        for (int k = 0; k < 70000; k++) begin
            step(S_B, 0, FRZ, 2'd0, 16'd0, 16'd0, 1'b0, "");
        end
        step(S_N, 1, DEF, 2'd3, 16'hFFFF, 16'd4, 1'b1, "sat_exit");
        step(S_N, 1, DEF, 2'd0, 16'hFFFF, 16'd4, 1'b1, "sat_hold");

        // Reset asserted in the middle of a memory wait.
        for (int k = 0; k < 3; k++) begin
            step(S_B, 0, FRZ, 2'd0, 16'd0, 16'd0, 1'b0, "");
        end
        step(S_RST, 1, DEF, 2'd3, 16'hFFFF, 16'd4, 1'b1, "rst_midwait_in");
        step(S_RST, 1, DEF, 2'd0, 16'd0, 16'd0, 1'b0, "rst_applied");
        step(S_N,   1, DEF, 2'd0, 16'd0, 16'd0, 1'b0, "post_rst");

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %0d expectations were never sampled", sbq.size());
        end
        if (total < 12) begin
            bad++;
            $display("FAIL only %0d checks were sampled", total);
        end
        if (bad == 0)
            $display("PASS: all %0d checks matched", total);
        else
            $display("FAIL: %0d of %0d checks mismatched", bad, total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset.
REQ-002 in_clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 in_rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_ifid_valid  input  1  IF/ID holds a real instruction.
REQ-005 in_ifid_rs1, in_ifid_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 in_ifid_uses_rs1, in_ifid_uses_rs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-007 in_idex_memread  input  1  the instruction in EX is a load.
REQ-008 in_idex_rd  input  5  destination register of the instruction in EX.
REQ-009 in_ex_redirect  input  1  branch taken, jal or jalr resolved in EX.
REQ-010 in_dmem_busy  input  1  data memory not ready; the pipeline must freeze.
REQ-011 out_pc_write, out_ifid_write  output  1 each  enables for the PC and IF/ID registers.
REQ-012 out_idex_bubble  output  1  zero the ID/EX control fields.
REQ-013 out_ifid_flush, out_idex_flush  output  1 each  invalidate the IF/ID and ID/EX registers.
REQ-014 out_exmem_write, out_memwb_write  output  1 each  enables for the EX/MEM and MEM/WB registers.
REQ-015 out_state  output  2  current FSM state.
REQ-016 out_stall_count, out_flush_count  output  16 each  saturating performance counters.
REQ-017 out_mem_timeout  output  1  sticky flag for a memory-wait watchdog expiry.

Function
REQ-018 FSM states are RUN=00, LU_STALL=01, FLUSH=10, MEM_WAIT=11; state is registered and outputs are Mealy (current state plus current inputs).
REQ-019 A load-use hazard is defined as all of the following:
- in_ifid_valid = 1
- in_idex_memread = 1
- in_idex_rd != 0
- in_idex_rd matches rs1 with uses_rs1 = 1, or matches rs2 with uses_rs2 = 1
REQ-020 Event priority SHALL be dmem_busy, then redirect, then load-use hazard.
REQ-021 Default outputs are every write enable = 1 and every flush or bubble = 0.
REQ-022 RUN with busy: all four write enables = 0; next state MEM_WAIT.
REQ-023 RUN with redirect (no busy): out_ifid_flush = 1 and out_idex_flush = 1 in the same cycle; next state FLUSH.
REQ-024 RUN with hazard only: out_pc_write = 0, out_ifid_write = 0, out_idex_bubble = 1; next state LU_STALL.
REQ-025 LU_STALL and FLUSH each last exactly one cycle.
- Hazard detection is masked in both states.
- Busy and redirect are evaluated exactly as in RUN.
- With neither busy nor redirect, next state is RUN.
REQ-026 MEM_WAIT holds all write enables at 0, asserts no flush and stays while busy; on busy = 0 it returns to RUN with no output action in that cycle.
REQ-027 A redirect asserted during MEM_WAIT is not acted on until after exit (EX is frozen, so the redirect is re-presented in RUN).
REQ-028 out_stall_count increments by 1 in each cycle that asserts out_idex_bubble or is spent in MEM_WAIT; out_flush_count increments by 1 per redirect flush cycle; both saturate at 0xFFFF.
REQ-029 A watchdog counter (8 bit) counts consecutive MEM_WAIT cycles and clears on exit; out_mem_timeout sets when the count reaches 255 and stays set until reset.
REQ-030 A simultaneous hazard and redirect resolves as flush only: no bubble, and no stall count.

Reset
REQ-031 While in_rst_n = 0 at a clock edge:
- state becomes RUN
- both counters and the watchdog become 0
- out_mem_timeout becomes 0
REQ-032 While in reset, outputs SHALL equal RUN defaults with hazard detection masked; reset mid-stall or mid-wait aborts to RUN.

Structure
REQ-033 A shared package SHALL hold the state encoding, counter width 16, watchdog width 8 and WATCHDOG_LIMIT = 255.
REQ-034 A sub-module sat_counter (parameterised width, increment, synchronous active-low clear) SHALL be instantiated for each performance counter.

Verification
REQ-035 Load-use hazard: idex_memread = 1, idex_rd = 5, ifid_rs2 = 5 with uses_rs2 = 1 -> one cycle of pc_write = 0, ifid_write = 0, idex_bubble = 1; then LU_STALL; then RUN; stall_count = 1.
REQ-036 Zero register: idex_rd = 0 = ifid_rs1 with memread = 1 -> no stall; state stays RUN.
REQ-037 Conflict: redirect with a hazard in the same cycle -> both flushes = 1, idex_bubble = 0; flush_count = 1, stall_count = 0.
REQ-038 Memory wait: busy held 3 cycles -> three cycles of all write enables = 0 in MEM_WAIT, then RUN; stall_count = 3.
REQ-039 Watchdog: busy held 260 cycles -> out_mem_timeout rises after 255 MEM_WAIT cycles, stays 1 after busy drops, and clears only on reset.
REQ-040 Saturation and reset: 70000 stall cycles -> stall_count = 0xFFFF; reset asserted mid-MEM_WAIT -> state 00 and counters 0 at the next edge.
